// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI serial-to-parallel stage and the command RAM.
// The master drives framed command words; the slave returns read data and error strobes.
interface spi_ram_burst_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic              burst_en;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              addr_err;
  logic              seq_err;

  modport master (
    output din, rx_valid, burst_en,
    input  dout, tx_valid, addr_err, seq_err
  );

  modport slave (
    input  din, rx_valid, burst_en,
    output dout, tx_valid, addr_err, seq_err
  );
endinterface

// File: rtl/spi_ram_burst.sv
// Parametrised single-port command RAM behind the SPI slave: opcode-driven pointer loads,
// burst auto-increment with wrap at MEM_DEPTH, read arming, and one-cycle error pulses.
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_ram_burst_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_WADDR = 2'b00,
    OP_WDATA = 2'b01,
    OP_RADDR = 2'b10,
    OP_RDATA = 2'b11
  } op_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  op_e               op;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] addr;
  logic              addr_ok;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              rd_armed_q, rd_armed_d;
  logic              tx_valid_q, tx_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              seq_err_q, seq_err_d;
  logic [DATA_W-1:0] dout_q;
  logic              mem_we;
  logic              rd_fire;

  assign op      = op_e'(bus.din[DATA_W+1:DATA_W]);
  assign payload = bus.din[DATA_W-1:0];
  // Payload bits above ADDR_W never reach the pointers.
  assign addr    = payload[ADDR_W-1:0];
  assign addr_ok = ({1'b0, addr} < DEPTH_EXT);

  // Wrap explicitly at MEM_DEPTH-1 so non-power-of-two depths stay in range.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal gets a default before the case, so no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_armed_d = rd_armed_q;
    tx_valid_d = 1'b0;
    addr_err_d = 1'b0;
    seq_err_d  = 1'b0;
    mem_we     = 1'b0;
    rd_fire    = 1'b0;
    if (bus.rx_valid) begin
      unique case (op)
        OP_WADDR: begin
          if (addr_ok) wr_ptr_d = addr;
          else         addr_err_d = 1'b1;
        end
        OP_WDATA: begin
          mem_we = 1'b1;
          if (bus.burst_en) wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        OP_RADDR: begin
          if (addr_ok) begin
            rd_ptr_d   = addr;
            rd_armed_d = 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        OP_RDATA: begin
          if (rd_armed_q) begin
            rd_fire    = 1'b1;
            tx_valid_d = 1'b1;
            if (bus.burst_en) rd_ptr_d = ptr_inc(rd_ptr_q);
            else              rd_armed_d = 1'b0;
          end else begin
            seq_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_armed_q <= 1'b0;
      tx_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      seq_err_q  <= 1'b0;
      dout_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_armed_q <= rd_armed_d;
      tx_valid_q <= tx_valid_d;
      addr_err_q <= addr_err_d;
      seq_err_q  <= seq_err_d;
      if (rd_fire) dout_q <= mem_q[rd_ptr_q];
    end
  end

  // NOTE: the array has no reset so it maps onto a plain RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= payload;
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.addr_err = addr_err_q;
  assign bus.seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: three builds (256x8, 200x8, 1024x16) share one clock and reset;
// expected read data is queued when a read is issued and popped when tx_valid appears.
module tb_spi_ram_burst;

  localparam int A = 0;
  localparam int B = 1;
  localparam int C = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_ram_burst_if #(.DATA_W(8))  if_a ();
  spi_ram_burst_if #(.DATA_W(8))  if_b ();
  spi_ram_burst_if #(.DATA_W(16)) if_c ();

  spi_ram_burst #(.DATA_W(8),  .ADDR_W(8),  .MEM_DEPTH(256))  u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  spi_ram_burst #(.DATA_W(8),  .ADDR_W(8),  .MEM_DEPTH(200))  u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  spi_ram_burst #(.DATA_W(16), .ADDR_W(10), .MEM_DEPTH(1024)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] sb_q[$];
  logic [15:0] hold [3];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    if_a.rx_valid = 1'b0; if_a.burst_en = 1'b0; if_a.din = '0;
    if_b.rx_valid = 1'b0; if_b.burst_en = 1'b0; if_b.din = '0;
    if_c.rx_valid = 1'b0; if_c.burst_en = 1'b0; if_c.din = '0;
  endtask

  task automatic sample(input int sel, output logic [15:0] d, output logic tx, output logic ae,
                        output logic se);
    case (sel)
      A:       begin d = 16'(if_a.dout); tx = if_a.tx_valid; ae = if_a.addr_err; se = if_a.seq_err; end
      B:       begin d = 16'(if_b.dout); tx = if_b.tx_valid; ae = if_b.addr_err; se = if_b.seq_err; end
      default: begin d = if_c.dout;      tx = if_c.tx_valid; ae = if_c.addr_err; se = if_c.seq_err; end
    endcase
  endtask

  task automatic check_outputs(input int sel, input string tag, input logic exp_tx,
                               input logic exp_ae, input logic exp_se);
    logic [15:0] d;
    logic        tx, ae, se;
    logic [15:0] exp_d;
    sample(sel, d, tx, ae, se);
    check({tag, ".tx_valid"}, 16'(tx), 16'(exp_tx));
    check({tag, ".addr_err"}, 16'(ae), 16'(exp_ae));
    check({tag, ".seq_err"},  16'(se), 16'(exp_se));
    if (sb_q.size() != 0) begin
      exp_d = sb_q.pop_front();
      if (tx) check({tag, ".dout"}, d, exp_d);
    end else begin
      check({tag, ".dout_hold"}, d, hold[sel]);
    end
  endtask

  // Drive one command at a falling edge; the response is visible at the next falling edge.
  task automatic cmd(input int sel, input logic [1:0] op, input logic [15:0] pl, input logic burst,
                     input logic exp_tx, input logic [15:0] exp_d, input logic exp_ae,
                     input logic exp_se, input string tag);
    idle_all();
    case (sel)
      A:       begin if_a.din = {op, pl[7:0]}; if_a.burst_en = burst; if_a.rx_valid = 1'b1; end
      B:       begin if_b.din = {op, pl[7:0]}; if_b.burst_en = burst; if_b.rx_valid = 1'b1; end
      default: begin if_c.din = {op, pl};      if_c.burst_en = burst; if_c.rx_valid = 1'b1; end
    endcase
    if (exp_tx) begin
      sb_q.push_back(exp_d);
      hold[sel] = exp_d;
    end
    @(negedge clk);
    check_outputs(sel, tag, exp_tx, exp_ae, exp_se);
  endtask

  task automatic idle_chk(input int sel, input string tag);
    idle_all();
    @(negedge clk);
    check_outputs(sel, tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    logic        tx, ae, se;
    for (int i = 0; i < 3; i++) hold[i] = '0;
    idle_all();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check_outputs(i, "reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Read straight out of reset is unarmed.
    cmd(A, 2'b11, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, "rd_unarmed_after_reset");

    // Single write/read, then a second read needs re-arming.
    cmd(A, 2'b00, 16'h0005, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, "waddr_05");
    cmd(A, 2'b01, 16'h00A5, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, "wdata_A5");
    cmd(A, 2'b10, 16'h0005, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, "raddr_05");
    cmd(A, 2'b11, 16'h0000, 1'b0, 1'b1, 16'hA5, 1'b0, 1'b0, "rd_A5");
    cmd(A, 2'b11, 16'h0000, 1'b0, 1'b0, 16'h0,  1'b0, 1'b1, "rd_disarmed");
    idle_chk(A, "idle_after_seq_err");

    // Burst write across the top of the 256-word array, then burst read back.
    cmd(A, 2'b00, 16'h00FE, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0, "waddr_FE");
    cmd(A, 2'b01, 16'h0011, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0, "bw_11");
    cmd(A, 2'b01, 16'h0022, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0, "bw_22");
    cmd(A, 2'b01, 16'h0033, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0, "bw_33_wrap");
    cmd(A, 2'b10, 16'h00FE, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0, "raddr_FE");
    cmd(A, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h11, 1'b0, 1'b0, "br_11");
    cmd(A, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h22, 1'b0, 1'b0, "br_22");
    cmd(A, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h33, 1'b0, 1'b0, "br_33_wrap");

    // Read immediately after a write to the same address.
    cmd(A, 2'b00, 16'h0040, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, "waddr_40");
    cmd(A, 2'b10, 16'h0040, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, "raddr_40");
    cmd(A, 2'b01, 16'h005A, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, "wdata_5A");
    cmd(A, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h5A, 1'b0, 1'b0, "raw_5A");

    // Reset pulse in the middle of a 4-beat burst read.
    cmd(A, 2'b10, 16'h00FE, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0, "raddr_FE_2");
    cmd(A, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h11, 1'b0, 1'b0, "br2_11");
    cmd(A, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h22, 1'b0, 1'b0, "br2_22");
    idle_all();
    rst_n = 1'b0;
    #1;
    sample(A, d, tx, ae, se);
    check("midburst_reset.tx_valid", 16'(tx), 16'h0);
    check("midburst_reset.dout", d, 16'h0);
    for (int i = 0; i < 3; i++) hold[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cmd(A, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h0,  1'b0, 1'b1, "rd_after_midburst_reset");

    // Depth-200 build: range check and wrap at 199.
    cmd(B, 2'b00, 16'h0010, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, "b_waddr_10");
    cmd(B, 2'b00, 16'h00C8, 1'b0, 1'b0, 16'h0,  1'b1, 1'b0, "b_waddr_C8_err");
    cmd(B, 2'b01, 16'h0077, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, "b_wdata_77");
    cmd(B, 2'b10, 16'h00C8, 1'b0, 1'b0, 16'h0,  1'b1, 1'b0, "b_raddr_C8_err");
    cmd(B, 2'b11, 16'h0000, 1'b0, 1'b0, 16'h0,  1'b0, 1'b1, "b_rd_still_unarmed");
    cmd(B, 2'b10, 16'h0010, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, "b_raddr_10");
    cmd(B, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h77, 1'b0, 1'b0, "b_rd_77_old_addr");
    cmd(B, 2'b00, 16'h00C7, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0, "b_waddr_C7");
    cmd(B, 2'b01, 16'h00AA, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0, "b_bw_AA");
    cmd(B, 2'b01, 16'h00BB, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0, "b_bw_BB_wrap");
    cmd(B, 2'b10, 16'h0000, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, "b_raddr_00");
    cmd(B, 2'b11, 16'h0000, 1'b0, 1'b1, 16'hBB, 1'b0, 1'b0, "b_rd_00_BB");
    cmd(B, 2'b10, 16'h00C7, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0, "b_raddr_C7");
    cmd(B, 2'b11, 16'h0000, 1'b1, 1'b1, 16'hAA, 1'b0, 1'b0, "b_br_AA");
    cmd(B, 2'b11, 16'h0000, 1'b1, 1'b1, 16'hBB, 1'b0, 1'b0, "b_br_BB_wrap");

    // 16-bit data / 10-bit address build.
    cmd(C, 2'b00, 16'h03FF, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, "c_waddr_3FF");
    cmd(C, 2'b01, 16'hBEEF, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, "c_wdata_BEEF");
    cmd(C, 2'b10, 16'h03FF, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, "c_raddr_3FF");
    cmd(C, 2'b11, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, "c_rd_BEEF");
    cmd(C, 2'b00, 16'hFC00, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, "c_waddr_FC00_upper_ignored");
    cmd(C, 2'b01, 16'h1234, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, "c_wdata_1234");
    cmd(C, 2'b10, 16'h0000, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, "c_raddr_000");
    cmd(C, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, "c_rd_1234");
    idle_chk(C, "c_idle");

    check("scoreboard_empty", 16'(sb_q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
